// File: rtl/serial_word_tx_if.sv
// Load handshake and serial output bundle for serial_word_tx.
// master = word source / serial consumer side, slave = the transmitter.
interface serial_word_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             ser_bit;
  logic             ser_clr;
  logic             ser_valid;
  logic             busy;
  logic             word_done;

  modport master (
    output load_data, load_valid,
    input  load_ready, ser_bit, ser_clr, ser_valid, busy, word_done
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, ser_bit, ser_clr, ser_valid, busy, word_done
  );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: clear pulse, then WIDTH bits LSB first.
// Optional trailing even-parity bit when SER_PARITY_EN is defined.
module serial_word_tx #(
  parameter int WIDTH = 8
) (
  input  logic              t_clk,
  input  logic              r,
  serial_word_tx_if.slave   bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    PAR   = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             ser_bit_r;
  logic             ser_clr_r;
  logic             ser_valid_r;
  logic             busy_r;
  logic             word_done_r;
  logic             load_ready_s;

`ifdef SER_PARITY_EN
  logic             par_r;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  // Ready in idle and on the final cycle of a word, which enables back-to-back loads
  always_comb begin
`ifdef SER_PARITY_EN
    load_ready_s = (state_r == IDLE) || (state_r == PAR);
`else
    load_ready_s = (state_r == IDLE) || ((state_r == SHIFT) && (cnt_r == LAST));
`endif
  end

  // Word sequencer with outputs registered alongside the state they describe
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_r     <= IDLE;
      shreg_r     <= '0;
      cnt_r       <= '0;
      ser_bit_r   <= 1'b0;
      ser_clr_r   <= 1'b0;
      ser_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      word_done_r <= 1'b0;
`ifdef SER_PARITY_EN
      par_r       <= 1'b0;
`endif
    end else if (load_ready_s) begin
      cnt_r       <= '0;
      ser_bit_r   <= 1'b0;
      ser_valid_r <= 1'b0;
      word_done_r <= 1'b0;
      if (bus.load_valid) begin
        state_r   <= CLR;
        shreg_r   <= bus.load_data;
        ser_clr_r <= 1'b1;
        busy_r    <= 1'b1;
`ifdef SER_PARITY_EN
        par_r     <= even_parity(bus.load_data);
`endif
      end else begin
        state_r   <= IDLE;
        ser_clr_r <= 1'b0;
        busy_r    <= 1'b0;
      end
    end else begin
      ser_clr_r <= 1'b0;
      case (state_r)
        CLR: begin
          state_r     <= SHIFT;
          cnt_r       <= '0;
          ser_bit_r   <= shreg_r[0];
          shreg_r     <= {1'b0, shreg_r[WIDTH-1:1]};
          ser_valid_r <= 1'b1;
          busy_r      <= 1'b1;
          word_done_r <= 1'b0;
        end
        SHIFT: begin
`ifdef SER_PARITY_EN
          if (cnt_r == LAST) begin
            state_r     <= PAR;
            cnt_r       <= '0;
            ser_bit_r   <= par_r;
            ser_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            word_done_r <= 1'b1;
          end else begin
            cnt_r       <= cnt_r + CW'(1);
            ser_bit_r   <= shreg_r[0];
            shreg_r     <= {1'b0, shreg_r[WIDTH-1:1]};
            ser_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            word_done_r <= 1'b0;
          end
`else
          cnt_r       <= cnt_r + CW'(1);
          ser_bit_r   <= shreg_r[0];
          shreg_r     <= {1'b0, shreg_r[WIDTH-1:1]};
          ser_valid_r <= 1'b1;
          busy_r      <= 1'b1;
          word_done_r <= ((cnt_r + CW'(1)) == LAST);
`endif
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= '0;
          ser_bit_r   <= 1'b0;
          ser_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          word_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready_s;
  assign bus.ser_bit    = ser_bit_r;
  assign bus.ser_clr    = ser_clr_r;
  assign bus.ser_valid  = ser_valid_r;
  assign bus.busy       = busy_r;
  assign bus.word_done  = word_done_r;

endmodule
